// File: rtl/sr_ctrl_pkg.sv
// Shared types for the SR latch controller.
// State encoding and latch operation codes.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_SETTLE,
    S_GAP
  } state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// req/ptr/en in; one-hot grant, id, any_valid out.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] id,
  output logic                    any_valid
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] j;

  // Scan upward from ptr with wrap;
  // first valid requester wins.
  always_comb begin
    grant     = '0;
    id        = '0;
    any_valid = 1'b0;
    j         = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (!any_valid && req[j]) begin
        any_valid = 1'b1;
        grant[j]  = en;
        id        = j;
      end
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer/arbiter driving a shared NAND SR latch.
// req_* handshake in; sbar/rbar pulses out; q_fb back.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int PW         = 2,
  parameter int SETTLE_MAX = 4,
  parameter int GAP        = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_op,
  output logic [NREQ-1:0]         req_ready,
  output logic                    sbar,
  output logic                    rbar,
  input  logic                    q_fb,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [$clog2(NREQ)-1:0] err_id
);

  localparam int IW  = $clog2(NREQ);
  localparam int PCW = $clog2(PW + 1);
  localparam int SCW = $clog2(SETTLE_MAX + 1);
  localparam int GCW = $clog2(GAP + 1);

  localparam logic [PCW-1:0] P_LAST = PCW'(PW - 1);
  localparam logic [SCW-1:0] S_LAST =
    SCW'(SETTLE_MAX - 1);
  localparam logic [GCW-1:0] G_LAST = GCW'(GAP - 1);
  localparam logic [IW-1:0]  ID_MAX = IW'(NREQ - 1);

  state_t state, nxt;

  logic [IW-1:0]   ptr, id_q, gid;
  logic [NREQ-1:0] grant;
  logic            any, en, xfer;
  logic            op_q, op_n;
  logic            q_s1, q_s2, match;
  logic [PCW-1:0]  pcnt;
  logic [SCW-1:0]  scnt;
  logic [GCW-1:0]  gcnt;
  logic            sbar_q, rbar_q;

  // Grants are suppressed while reset is held
  // so req_ready drops without a clock.
  assign en   = (state == S_IDLE) && reset_n;
  assign xfer = any && en;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .en       (en),
    .grant    (grant),
    .id       (gid),
    .any_valid(any)
  );

  assign req_ready = grant;
  assign op_n      = xfer ? req_op[gid] : op_q;
  assign match     = (q_s2 == op_q);
  assign sbar      = sbar_q;
  assign rbar      = rbar_q;
  assign err_id    = id_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_s1 <= 1'b0;
      q_s2 <= 1'b0;
    end else begin
      q_s1 <= q_fb;
      q_s2 <= q_s1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (xfer) nxt = S_PULSE;
      S_PULSE:  if (pcnt == P_LAST) nxt = S_SETTLE;
      S_SETTLE: if (match || scnt == S_LAST)
                  nxt = S_GAP;
      S_GAP:    if (gcnt == G_LAST) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_SETTLE) && match;
    err  = (state == S_SETTLE) && !match &&
           (scnt == S_LAST);
  end

  // Counters clear outside their state, so each
  // starts from zero on entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      scnt <= '0;
      gcnt <= '0;
    end else begin
      pcnt <= (state == S_PULSE)  ? pcnt + 1'b1 : '0;
      scnt <= (state == S_SETTLE) ? scnt + 1'b1 : '0;
      gcnt <= (state == S_GAP)    ? gcnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr  <= '0;
      id_q <= '0;
      op_q <= OP_RESET;
    end else if (xfer) begin
      id_q <= gid;
      op_q <= req_op[gid];
      ptr  <= (gid == ID_MAX) ? '0 : gid + 1'b1;
    end
  end

  // Lines are registered from the next state, so
  // at most one can be low and both idle high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sbar_q <= 1'b1;
      rbar_q <= 1'b1;
    end else begin
      sbar_q <= !(nxt == S_PULSE && op_n == OP_SET);
      rbar_q <= !(nxt == S_PULSE && op_n == OP_RESET);
    end
  end

endmodule
